rv_lsu: RTL and testbench
=========================

Name: rv_lsu

Overview:
Memory-access stage that consumes the execute stage's store/load outputs: address, write data, byte selects, funct3, rd and result. It drives a single-outstanding request/acknowledge data bus, then aligns and sign/zero-extends load data. It presents a registered writeback bundle to the register-file stage. Non-memory ops pass through with one cycle of latency; memory ops stall upstream via o_ready until the bus acknowledges.

Parameters:
TIMEOUT_CYCLES, 255, bus wait limit before a fault is raised; 0 disables the timeout.
CNT_BITS, 8, width of the timeout counter; must be large enough to hold TIMEOUT_CYCLES.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous reset, active-high
i_flush  in  1  kill the current and in-flight op
i_load  in  1  op is a load (res_src memory)
i_store  in  1  op is a store
i_reg_write  in  1  op writes rd
i_rd  in  5  destination register
i_result  in  32  ALU/CSR/pc_next result for non-load ops
i_addr  in  32  effective address (adder output)
i_wdata  in  32  lane-aligned store data
i_wsel  in  4  store byte enables
i_funct3  in  3  access size and sign
o_ready  out  1  stage can accept an op this cycle
o_dbus_req  out  1  bus request
o_dbus_we  out  1  write enable
o_dbus_addr  out  32  word address, bits [1:0] forced to 00
o_dbus_wsel  out  4  byte enables; all ones for loads
o_dbus_wdata  out  32  store data
i_dbus_ack  in  1  transfer complete
i_dbus_rdata  in  32  read data, valid with ack
o_reg_write  out  1  writeback enable
o_rd  out  5  writeback register
o_result  out  32  writeback data
o_fault  out  1  one-cycle pulse: misaligned access or bus timeout

Behaviour:
- States: IDLE and BUS. Reset puts the block in IDLE. All outputs reset to 0 except o_ready, which resets to 1.
- o_ready = (state==IDLE). An op is accepted on a cycle where o_ready=1 and i_flush=0.
- Non-memory op accepted:
  - next cycle: o_reg_write=i_reg_write, o_rd=i_rd, o_result=i_result.
- Misalignment check (memory op only):
  - funct3[1:0]=01 with addr[0]=1 is misaligned.
  - funct3[1:0]=10 with addr[1:0]!=0 is misaligned.
  - Response: no bus request, stay in IDLE, o_fault=1 next cycle, o_reg_write=0.
- Aligned memory op accepted:
  - Register address, data, wsel, funct3, addr[1:0] and rd; enter BUS.
  - o_dbus_req=1 from the next cycle. Bus outputs stay stable until an ack is sampled.
- In BUS:
  - The timeout counter increments every cycle.
  - On i_dbus_ack: drop req on the following edge and return to IDLE.
  - A load produces o_reg_write=1 with aligned data on the cycle after the ack. A store produces no writeback.
  - Minimum memory-op latency: accept -> req (1 cycle) -> ack -> writeback (1 cycle).
- Load alignment:
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; LW takes the whole word.
  - funct3[2]=0 sign-extends, funct3[2]=1 zero-extends.
- Timeout (TIMEOUT_CYCLES!=0): when the counter reaches TIMEOUT_CYCLES without an ack:
  - Drop req, go to IDLE, pulse o_fault, no writeback.
  - A later stray ack while in IDLE is ignored.
- Flush:
  - In IDLE, the presented op is dropped and all outputs are 0 next cycle.
  - In BUS, the transaction is not aborted: req is held until ack or timeout, and the killed flag suppresses writeback and fault.
- Ack and flush in the same cycle: the transfer completes, writeback is suppressed.
- Ack and timeout in the same cycle: the ack wins, with normal completion and no fault.
- Writeback outputs and o_fault are single-cycle; they return to 0 unless a new op completes.
- Asynchronous reset mid-transaction: req drops immediately and the state returns to IDLE. The bus slave must tolerate the abandoned request.

Test Plan:
- Non-memory op: reg_write=1, rd=5, result=0x1234 -> next cycle o_reg_write=1, o_rd=5, o_result=0x1234; o_ready stays 1.
- LB at addr 0x103, rdata 0x80FF1234, ack after 2 cycles:
  - o_dbus_addr=0x100, wsel=0xF; o_ready low for 3 cycles.
  - o_result=0xFFFFFF80.
- LHU at 0x102, rdata 0x80FF1234 -> o_result=0x000080FF. LH at 0x000, same rdata -> 0x00001234.
- SW at 0x200, wdata 0xDEADBEEF, wsel 0xF, ack delay 3:
  - req/we/data stable for 4 cycles; no o_reg_write.
- Misaligned cases:
  - LW at 0x101 -> no req, o_fault=1 for one cycle.
  - Timeout with TIMEOUT_CYCLES=4 and ack never asserted -> req drops after 4 cycles, o_fault pulse, o_ready=1.
- Flush and reset:
  - Flush asserted while in BUS -> req held until ack, no writeback.
  - i_reset asserted mid-BUS -> o_dbus_req=0 in the same cycle, o_ready=1.

Source files
------------

// File: rtl/rv_lsu.sv
// rv_lsu: memory-access pipeline stage.
//
// This stage takes the execute-stage outputs and handles one op at a time.
//   - Non-memory ops: the writeback bundle appears one cycle after the op is accepted.
//   - Aligned loads and stores: the op is registered and the stage issues a single
//     outstanding request on the data bus. It holds that request until the bus acks
//     or the transfer times out. Load data is aligned and extended before writeback.
//   - Misaligned accesses and bus timeouts: the stage gives a one-cycle fault pulse
//     and does no writeback.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_flush               kill the presented op (IDLE) or the in-flight one (BUS)
//   i_load / i_store      op class; i_reg_write / i_rd / i_result for writeback
//   i_addr / i_wdata /    effective address, lane-aligned store data,
//   i_wsel / i_funct3     byte enables, access size and sign
//   o_ready               stage can accept an op this cycle
//   o_dbus_*              request/ack data bus (word address, byte enables, data)
//   i_dbus_ack/_rdata     transfer complete; read data valid with ack
//   o_reg_write/o_rd/     registered writeback bundle
//   o_result
//   o_fault               one-cycle pulse on misalignment or bus timeout
module rv_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_BITS       = 8
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_flush,
   input  logic        i_load,
   input  logic        i_store,
   input  logic        i_reg_write,
   input  logic [4:0]  i_rd,
   input  logic [31:0] i_result,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wsel,
   input  logic [2:0]  i_funct3,
   output logic        o_ready,
   output logic        o_dbus_req,
   output logic        o_dbus_we,
   output logic [31:0] o_dbus_addr,
   output logic [3:0]  o_dbus_wsel,
   output logic [31:0] o_dbus_wdata,
   input  logic        i_dbus_ack,
   input  logic [31:0] i_dbus_rdata,
   output logic        o_reg_write,
   output logic [4:0]  o_rd,
   output logic [31:0] o_result,
   output logic        o_fault
);

   typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

   // Counter value seen during the last permitted bus cycle. With this value the
   // request stays high for exactly TIMEOUT_CYCLES cycles.
   localparam logic [CNT_BITS-1:0] CNT_LAST =
      CNT_BITS'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);

   state_t state, state_next;

   logic [31:0]         req_addr;
   logic [31:0]         req_wdata;
   logic [3:0]          req_wsel;
   logic                req_we;
   logic [2:0]          req_funct3;
   logic [1:0]          req_off;
   logic [4:0]          req_rd;
   logic                killed;
   logic [CNT_BITS-1:0] cnt;

   logic accept;
   logic is_mem;
   logic misaligned;
   logic timeout;
   logic kill_now;

   assign accept   = (state == IDLE) && !i_flush;
   assign is_mem   = i_load | i_store;
   assign timeout  = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
   // A flush in the ack or timeout cycle must already suppress that completion.
   assign kill_now = killed | i_flush;

   always_comb begin
      case (i_funct3[1:0])
         2'b01:   misaligned = i_addr[0];
         2'b10:   misaligned = |i_addr[1:0];
         default: misaligned = 1'b0;
      endcase
   end

   // Pick the addressed byte or half-word out of the read word, then sign-extend it
   // (funct3[2]=0) or zero-extend it (funct3[2]=1).
   function automatic logic [31:0] align_load(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3[1:0])
         2'b00:   return {{24{b[7] & ~f3[2]}}, b};
         2'b01:   return {{16{h[15] & ~f3[2]}}, h};
         default: return word;
      endcase
   endfunction

   // NOTE: state updates use non-blocking assignments. That way every flop samples the
   // values from before the edge, whatever order the processes are evaluated in.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_next;
   end

   // NOTE: state_next is given its default first. If it were not assigned on every
   // path, synthesis would infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept && is_mem && !misaligned) state_next = BUS;
         BUS:  if (i_dbus_ack || timeout)           state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         req_addr    <= '0;
         req_wdata   <= '0;
         req_wsel    <= '0;
         req_we      <= 1'b0;
         req_funct3  <= '0;
         req_off     <= '0;
         req_rd      <= '0;
         killed      <= 1'b0;
         cnt         <= '0;
         o_reg_write <= 1'b0;
         o_rd        <= '0;
         o_result    <= '0;
         o_fault     <= 1'b0;
      end else begin
         // Writeback and fault are single-cycle unless something completes this edge.
         o_reg_write <= 1'b0;
         o_rd        <= '0;
         o_result    <= '0;
         o_fault     <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!is_mem) begin
                     o_reg_write <= i_reg_write;
                     o_rd        <= i_rd;
                     o_result    <= i_result;
                  end else if (misaligned) begin
                     o_fault <= 1'b1;
                  end else begin
                     req_addr   <= {i_addr[31:2], 2'b00};
                     req_wdata  <= i_wdata;
                     req_wsel   <= i_store ? i_wsel : 4'hF;
                     req_we     <= i_store;
                     req_funct3 <= i_funct3;
                     req_off    <= i_addr[1:0];
                     req_rd     <= i_rd;
                     killed     <= 1'b0;
                     cnt        <= '0;
                  end
               end
            end
            BUS: begin
               cnt    <= cnt + 1'b1;
               killed <= kill_now;
               // An ack takes priority over a timeout that expires in the same cycle.
               if (i_dbus_ack) begin
                  if (!req_we && !kill_now) begin
                     o_reg_write <= 1'b1;
                     o_rd        <= req_rd;
                     o_result    <= align_load(i_dbus_rdata, req_funct3, req_off);
                  end
               end else if (timeout) begin
                  o_fault <= !kill_now;
               end
            end
         endcase
      end
   end

   assign o_ready    = (state == IDLE);
   assign o_dbus_req = (state == BUS);
   // The bus fields are gated by the request. Outside a transfer they read as zero,
   // so stale values from the previous transfer do not show.
   assign o_dbus_we    = o_dbus_req & req_we;
   assign o_dbus_addr  = o_dbus_req ? req_addr  : '0;
   assign o_dbus_wsel  = o_dbus_req ? req_wsel  : '0;
   assign o_dbus_wdata = o_dbus_req ? req_wdata : '0;

endmodule

// File: tb/tb_rv_lsu.sv
// Directed testbench for rv_lsu. The DUT is built with TIMEOUT_CYCLES=4.
// Inputs are driven and outputs sampled 1 ns after each rising clock edge.
module tb_rv_lsu;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_flush;
   logic        i_load;
   logic        i_store;
   logic        i_reg_write;
   logic [4:0]  i_rd;
   logic [31:0] i_result;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [3:0]  i_wsel;
   logic [2:0]  i_funct3;
   logic        o_ready;
   logic        o_dbus_req;
   logic        o_dbus_we;
   logic [31:0] o_dbus_addr;
   logic [3:0]  o_dbus_wsel;
   logic [31:0] o_dbus_wdata;
   logic        i_dbus_ack;
   logic [31:0] i_dbus_rdata;
   logic        o_reg_write;
   logic [4:0]  o_rd;
   logic [31:0] o_result;
   logic        o_fault;

   int total = 0;
   int bad   = 0;

   rv_lsu #(.TIMEOUT_CYCLES(4), .CNT_BITS(8)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
      .i_load(i_load), .i_store(i_store), .i_reg_write(i_reg_write),
      .i_rd(i_rd), .i_result(i_result), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_wsel(i_wsel), .i_funct3(i_funct3), .o_ready(o_ready),
      .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we), .o_dbus_addr(o_dbus_addr),
      .o_dbus_wsel(o_dbus_wsel), .o_dbus_wdata(o_dbus_wdata),
      .i_dbus_ack(i_dbus_ack), .i_dbus_rdata(i_dbus_rdata),
      .o_reg_write(o_reg_write), .o_rd(o_rd), .o_result(o_result), .o_fault(o_fault)
   );

   initial forever #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_flush = 0; i_load = 0; i_store = 0; i_reg_write = 0; i_rd = 0;
      i_result = 0; i_addr = 0; i_wdata = 0; i_wsel = 0; i_funct3 = 0;
   endtask

   task automatic present(input logic ld, input logic st, input logic rw,
                          input logic [4:0] rd, input logic [31:0] res,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [2:0] f3);
      i_load = ld; i_store = st; i_reg_write = rw; i_rd = rd; i_result = res;
      i_addr = addr; i_wdata = wd; i_wsel = ws; i_funct3 = f3;
   endtask

   // Runs one memory op. The DUT sees ack_delay request cycles without an ack, then
   // ack on the next one. i_flush is raised in the cycle numbered flush_at (-1 = never).
   // The task returns in the cycle after the ack and reports what the DUT showed.
   task automatic run_mem(input logic st, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [2:0] f3,
                          input logic [31:0] rdata, input int ack_delay, input int flush_at,
                          output int req_cycles, output int ready_low, output logic stable,
                          output logic [31:0] a0, output logic [3:0] s0, output logic we0,
                          output logic [31:0] d0, output logic wb_we,
                          output logic [4:0] wb_rd, output logic [31:0] wb_res,
                          output logic req_after);
      present(!st, st, !st, 5'd7, 32'h0, addr, wd, ws, f3);
      tick();
      idle_inputs();
      req_cycles = 0; ready_low = 0; stable = 1;
      a0 = o_dbus_addr; s0 = o_dbus_wsel; we0 = o_dbus_we; d0 = o_dbus_wdata;
      for (int n = 0; n < 20; n++) begin
         if (o_dbus_req) req_cycles++;
         if (!o_ready) ready_low++;
         if (o_dbus_addr !== a0 || o_dbus_wsel !== s0 || o_dbus_we !== we0 ||
             o_dbus_wdata !== d0 || o_dbus_req !== 1'b1) stable = 0;
         i_flush = (n == flush_at);
         if (n == ack_delay) begin
            i_dbus_ack = 1; i_dbus_rdata = rdata;
         end
         tick();
         i_flush = 0;
         if (i_dbus_ack) begin
            i_dbus_ack = 0; i_dbus_rdata = 0;
            break;
         end
      end
      wb_we = o_reg_write; wb_rd = o_rd; wb_res = o_result; req_after = o_dbus_req;
   endtask

   task automatic test_reset();
      i_reset = 1; idle_inputs(); i_dbus_ack = 0; i_dbus_rdata = 0;
      #12;
      total++;
      if ({o_ready, o_dbus_req, o_dbus_we, o_reg_write, o_fault} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_ctrl got=%b want=10000",
                  {o_ready, o_dbus_req, o_dbus_we, o_reg_write, o_fault});
      end
      total++;
      if ({o_dbus_addr, o_dbus_wdata, o_dbus_wsel, o_rd, o_result} !== '0) begin
         bad++;
         $display("FAIL reset_data addr=%h wdata=%h result=%h", o_dbus_addr, o_dbus_wdata, o_result);
      end
      i_reset = 0;
      tick();
   endtask

   task automatic test_passthru();
      present(0, 0, 1, 5'd5, 32'h1234, 32'h0, 32'h0, 4'h0, 3'b000);
      tick();
      total++;
      if ({o_reg_write, o_rd, o_result, o_ready} !== {1'b1, 5'd5, 32'h1234, 1'b1}) begin
         bad++;
         $display("FAIL passthru got we=%b rd=%0d res=%h rdy=%b want 1/5/00001234/1",
                  o_reg_write, o_rd, o_result, o_ready);
      end
      // back-to-back: a second op with reg_write=0 follows directly
      present(0, 0, 0, 5'd9, 32'hCAFE0000, 32'h0, 32'h0, 4'h0, 3'b000);
      tick();
      total++;
      if ({o_reg_write, o_rd, o_result} !== {1'b0, 5'd9, 32'hCAFE0000}) begin
         bad++;
         $display("FAIL back_to_back got we=%b rd=%0d res=%h want 0/9/cafe0000",
                  o_reg_write, o_rd, o_result);
      end
      idle_inputs();
      tick();
      total++;
      if ({o_reg_write, o_rd, o_result} !== '0) begin
         bad++;
         $display("FAIL passthru_clear got we=%b rd=%0d res=%h want 0", o_reg_write, o_rd, o_result);
      end
   endtask

   task automatic test_loads();
      int rc, rl; logic st, we0, wbw, ra; logic [31:0] a0, d0, wbr; logic [3:0] s0; logic [4:0] wrd;
      // LB 0x103, ack after 2 idle req cycles
      run_mem(0, 32'h103, 32'h0, 4'h0, 3'b000, 32'h80FF1234, 2, -1,
              rc, rl, st, a0, s0, we0, d0, wbw, wrd, wbr, ra);
      total++;
      if (a0 !== 32'h100 || s0 !== 4'hF || we0 !== 1'b0) begin
         bad++; $display("FAIL lb_bus addr=%h wsel=%h we=%b want 100/f/0", a0, s0, we0);
      end
      total++;
      if (rl !== 3 || rc !== 3 || st !== 1'b1) begin
         bad++; $display("FAIL lb_ready_low got=%0d req=%0d stable=%b want 3/3/1", rl, rc, st);
      end
      total++;
      if ({wbw, wrd, wbr, ra} !== {1'b1, 5'd7, 32'hFFFFFF80, 1'b0}) begin
         bad++; $display("FAIL lb_wb we=%b rd=%0d res=%h req=%b want 1/7/ffffff80/0", wbw, wrd, wbr, ra);
      end
      // LHU 0x102
      run_mem(0, 32'h102, 32'h0, 4'h0, 3'b101, 32'h80FF1234, 0, -1,
              rc, rl, st, a0, s0, we0, d0, wbw, wrd, wbr, ra);
      total++;
      if (wbw !== 1'b1 || wbr !== 32'h000080FF || rc !== 1) begin
         bad++; $display("FAIL lhu_wb we=%b res=%h req=%0d want 1/000080ff/1", wbw, wbr, rc);
      end
      // LH 0x000
      run_mem(0, 32'h000, 32'h0, 4'h0, 3'b001, 32'h80FF1234, 1, -1,
              rc, rl, st, a0, s0, we0, d0, wbw, wrd, wbr, ra);
      total++;
      if (wbw !== 1'b1 || wbr !== 32'h00001234) begin
         bad++; $display("FAIL lh_wb we=%b res=%h want 1/00001234", wbw, wbr);
      end
      // LBU 0x101 and LW 0x004
      run_mem(0, 32'h101, 32'h0, 4'h0, 3'b100, 32'h80FF1234, 0, -1,
              rc, rl, st, a0, s0, we0, d0, wbw, wrd, wbr, ra);
      total++;
      if (wbr !== 32'h00000012) begin
         bad++; $display("FAIL lbu_wb res=%h want 00000012", wbr);
      end
      run_mem(0, 32'h004, 32'h0, 4'h0, 3'b010, 32'h80FF1234, 0, -1,
              rc, rl, st, a0, s0, we0, d0, wbw, wrd, wbr, ra);
      total++;
      if (wbr !== 32'h80FF1234 || a0 !== 32'h4) begin
         bad++; $display("FAIL lw_wb res=%h addr=%h want 80ff1234/4", wbr, a0);
      end
   endtask

   task automatic test_store();
      int rc, rl; logic st, we0, wbw, ra; logic [31:0] a0, d0, wbr; logic [3:0] s0; logic [4:0] wrd;
      // ack on the 4th request cycle, which is also the timeout cycle: ack must win
      run_mem(1, 32'h200, 32'hDEADBEEF, 4'hF, 3'b010, 32'h0, 3, -1,
              rc, rl, st, a0, s0, we0, d0, wbw, wrd, wbr, ra);
      total++;
      if (rc !== 4 || st !== 1'b1) begin
         bad++; $display("FAIL sw_stable req_cycles=%0d stable=%b want 4/1", rc, st);
      end
      total++;
      if ({a0, d0, s0, we0} !== {32'h200, 32'hDEADBEEF, 4'hF, 1'b1}) begin
         bad++; $display("FAIL sw_bus addr=%h data=%h wsel=%h we=%b", a0, d0, s0, we0);
      end
      total++;
      if (wbw !== 1'b0 || o_fault !== 1'b0 || ra !== 1'b0 || o_ready !== 1'b1) begin
         bad++; $display("FAIL sw_done we=%b fault=%b req=%b rdy=%b want 0/0/0/1", wbw, o_fault, ra, o_ready);
      end
      // SB to byte 1: byte enables pass straight through
      run_mem(1, 32'h301, 32'h0000AB00, 4'h2, 3'b000, 32'h0, 0, -1,
              rc, rl, st, a0, s0, we0, d0, wbw, wrd, wbr, ra);
      total++;
      if (a0 !== 32'h300 || s0 !== 4'h2 || d0 !== 32'h0000AB00) begin
         bad++; $display("FAIL sb_bus addr=%h wsel=%h data=%h want 300/2/0000ab00", a0, s0, d0);
      end
   endtask

   task automatic test_misaligned();
      present(1, 0, 1, 5'd3, 32'h0, 32'h101, 32'h0, 4'h0, 3'b010);
      tick();
      idle_inputs();
      total++;
      if ({o_dbus_req, o_fault, o_reg_write, o_ready} !== 4'b0101) begin
         bad++; $display("FAIL lw_misaligned req/fault/we/rdy=%b want 0101",
                         {o_dbus_req, o_fault, o_reg_write, o_ready});
      end
      tick();
      total++;
      if (o_fault !== 1'b0 || o_dbus_req !== 1'b0) begin
         bad++; $display("FAIL fault_pulse fault=%b req=%b want 0/0", o_fault, o_dbus_req);
      end
      // LH at odd address
      present(1, 0, 1, 5'd3, 32'h0, 32'h001, 32'h0, 4'h0, 3'b001);
      tick();
      idle_inputs();
      total++;
      if ({o_dbus_req, o_fault} !== 2'b01) begin
         bad++; $display("FAIL lh_misaligned req/fault=%b want 01", {o_dbus_req, o_fault});
      end
      tick();
   endtask

   task automatic test_timeout();
      int cnt = 0;
      present(1, 0, 1, 5'd4, 32'h0, 32'h10, 32'h0, 4'h0, 3'b010);
      tick();
      idle_inputs();
      for (int n = 0; n < 20; n++) begin
         if (!o_dbus_req) break;
         cnt++;
         tick();
      end
      total++;
      if (cnt !== 4) begin
         bad++; $display("FAIL timeout_len req_cycles=%0d want 4", cnt);
      end
      total++;
      if ({o_fault, o_ready, o_reg_write} !== 3'b110) begin
         bad++; $display("FAIL timeout_fault fault/rdy/we=%b want 110", {o_fault, o_ready, o_reg_write});
      end
      tick();
      // stray ack in IDLE is ignored
      i_dbus_ack = 1; i_dbus_rdata = 32'h55555555;
      tick();
      i_dbus_ack = 0; i_dbus_rdata = 0;
      total++;
      if ({o_fault, o_reg_write, o_dbus_req, o_ready} !== 4'b0001) begin
         bad++; $display("FAIL stray_ack fault/we/req/rdy=%b want 0001",
                         {o_fault, o_reg_write, o_dbus_req, o_ready});
      end
   endtask

   task automatic test_flush();
      int rc, rl; logic st, we0, wbw, ra; logic [31:0] a0, d0, wbr; logic [3:0] s0; logic [4:0] wrd;
      // flush in first BUS cycle, ack two cycles later: request held, no writeback
      run_mem(0, 32'h40, 32'h0, 4'h0, 3'b010, 32'h12345678, 2, 0,
              rc, rl, st, a0, s0, we0, d0, wbw, wrd, wbr, ra);
      total++;
      if (rc !== 3 || st !== 1'b1 || wbw !== 1'b0 || o_fault !== 1'b0) begin
         bad++; $display("FAIL flush_bus req=%0d stable=%b we=%b fault=%b want 3/1/0/0", rc, st, wbw, o_fault);
      end
      // flush in the same cycle as ack
      run_mem(0, 32'h44, 32'h0, 4'h0, 3'b010, 32'h12345678, 1, 1,
              rc, rl, st, a0, s0, we0, d0, wbw, wrd, wbr, ra);
      total++;
      if (rc !== 2 || wbw !== 1'b0 || ra !== 1'b0) begin
         bad++; $display("FAIL flush_ack req=%0d we=%b req_after=%b want 2/0/0", rc, wbw, ra);
      end
      // flush in IDLE drops the presented op
      present(0, 0, 1, 5'd5, 32'h1234, 32'h0, 32'h0, 4'h0, 3'b000);
      i_flush = 1;
      tick();
      idle_inputs();
      total++;
      if ({o_reg_write, o_rd, o_result, o_fault, o_dbus_req, o_ready} !== {1'b0, 5'd0, 32'd0, 3'b001}) begin
         bad++; $display("FAIL flush_idle we=%b rd=%0d res=%h fault=%b req=%b rdy=%b",
                         o_reg_write, o_rd, o_result, o_fault, o_dbus_req, o_ready);
      end
   endtask

   task automatic test_async_reset();
      present(1, 0, 1, 5'd6, 32'h0, 32'h80, 32'h0, 4'h0, 3'b010);
      tick();
      idle_inputs();
      total++;
      if (o_dbus_req !== 1'b1) begin
         bad++; $display("FAIL areset_pre req=%b want 1", o_dbus_req);
      end
      #3 i_reset = 1;
      #1;
      total++;
      if (o_dbus_req !== 1'b0 || o_ready !== 1'b1) begin
         bad++; $display("FAIL areset_now req=%b rdy=%b want 0/1", o_dbus_req, o_ready);
      end
      #2 i_reset = 0;
      tick();
      total++;
      if ({o_dbus_req, o_ready, o_reg_write, o_fault} !== 4'b0100) begin
         bad++; $display("FAIL areset_after req/rdy/we/fault=%b want 0100",
                         {o_dbus_req, o_ready, o_reg_write, o_fault});
      end
   endtask

   initial begin
      test_reset();
      test_passthru();
      test_loads();
      test_store();
      test_misaligned();
      test_timeout();
      test_flush();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
